// File: rtl/vga_sync_recover.sv
// Recovers hcount/vcount/blanking from raw VGA hsync/vsync, tracks lock and flags timing errors.
// Optional err_cnt output enabled by VGA_SYNC_RECOVER_ERRCNT_EN.
module vga_sync_recover #(
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned H_TOTAL      = 1344,
    parameter int unsigned H_SYNC_START = 1048,
    parameter int unsigned H_SYNC_WIDTH = 136,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned V_TOTAL      = 806,
    parameter int unsigned V_SYNC_START = 771,
    parameter int unsigned V_SYNC_WIDTH = 6,
    parameter int unsigned LOCK_LINES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        locked,
    output logic        sync_err
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int unsigned CW  = 11;
    localparam int unsigned GLW = $clog2(LOCK_LINES + 1);

    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_SS    = CW'(H_SYNC_START);
    localparam logic [CW-1:0] H_SE    = CW'((H_SYNC_START + H_SYNC_WIDTH) % H_TOTAL);
    localparam logic [CW-1:0] H_ALIGN = CW'((H_SYNC_START + 1) % H_TOTAL);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_SS    = CW'(V_SYNC_START);
    localparam logic [CW-1:0] V_SE    = CW'(V_SYNC_START + V_SYNC_WIDTH);
    localparam logic [GLW-1:0] GL_MAX = GLW'(LOCK_LINES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_HTRACK = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic           hs_q, hs_d, hs_dly_q, hs_dly_d;
    logic           vs_q, vs_d, vs_dly_q, vs_dly_d;
    logic           vld1_q, vld1_d, vld2_q, vld2_d;
    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [GLW-1:0] good_q, good_d;
    logic [CW-1:0]  hcount_q, hcount_d, vcount_q, vcount_d;
    logic           hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic           hsync_q, hsync_d, vsync_q, vsync_d;
    logic           locked_q, locked_d, sync_err_q, sync_err_d;

    logic           h_rise, h_fall, v_rise, v_fall, h_wrap;
    logic           h_bad_rise, h_miss, h_bad_fall, v_bad_rise, v_bad_fall, v_outside;
    logic           err, load_v, lock_nxt;
    logic [CW-1:0]  h_next, v_next, v_cur;

    // Edges are only trusted once both pipeline stages hold post-reset samples.
    always_comb begin
        hs_d     = hsync_in;
        vs_d     = vsync_in;
        hs_dly_d = hs_q;
        vs_dly_d = vs_q;
        vld1_d   = 1'b1;
        vld2_d   = vld1_q;
        h_rise   = vld2_q & hs_q & ~hs_dly_q;
        h_fall   = vld2_q & ~hs_q & hs_dly_q;
        v_rise   = vld2_q & vs_q & ~vs_dly_q;
        v_fall   = vld2_q & ~vs_q & vs_dly_q;
        h_wrap   = (h_cnt_q == H_LAST);
        h_next   = h_wrap ? '0 : h_cnt_q + CW'(1);
        if (h_wrap) begin
            v_next = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end else begin
            v_next = v_cnt_q;
        end
        h_bad_rise = h_rise & (h_cnt_q != H_SS);
        h_miss     = (h_cnt_q == H_SS) & ~hs_q;
        h_bad_fall = h_fall & (h_cnt_q != H_SE);
        v_bad_rise = v_rise & ~((h_cnt_q == '0) & (v_cnt_q == V_SS));
        v_bad_fall = v_fall & ~((h_cnt_q == '0) & (v_cnt_q == V_SE));
        v_outside  = vs_q & ((v_cnt_q < V_SS) | (v_cnt_q >= V_SE));
    end

    // Lock FSM and recovered counters; h_cnt_q/v_cnt_q index the pixel held in hs_q/vs_q.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        good_d  = good_q;
        err     = 1'b0;
        load_v  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (h_rise) begin
                    h_cnt_d = H_ALIGN;
                    good_d  = '0;
                    state_d = ST_HTRACK;
                end
            end
            ST_HTRACK: begin
                h_cnt_d = h_next;
                v_cnt_d = v_next;
                if (h_bad_rise) begin
                    h_cnt_d = H_ALIGN;
                    good_d  = '0;
                end else if (h_fall) begin
                    if (h_cnt_q == H_SE) begin
                        good_d = (good_q == GL_MAX) ? good_q : good_q + GLW'(1);
                    end else begin
                        good_d = '0;
                    end
                end else if (h_miss) begin
                    good_d = '0;
                end
                if (!h_bad_rise && v_rise && (h_cnt_q == '0) && (good_q == GL_MAX)) begin
                    load_v  = 1'b1;
                    v_cnt_d = V_SS;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                h_cnt_d = h_next;
                v_cnt_d = v_next;
                err = h_bad_rise | h_miss | h_bad_fall | v_bad_rise | v_bad_fall | v_outside;
                if (h_bad_rise) begin
                    h_cnt_d = H_ALIGN;
                    good_d  = '0;
                    state_d = ST_HTRACK;
                end else if (err) begin
                    state_d = ST_SEARCH;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Registered outputs, forced to the blanked idle pattern whenever not locked.
    always_comb begin
        lock_nxt   = (state_d == ST_LOCKED);
        v_cur      = load_v ? V_SS : v_cnt_q;
        hcount_d   = lock_nxt ? h_cnt_q : '0;
        vcount_d   = lock_nxt ? v_cur : '0;
        hblnk_d    = lock_nxt ? (h_cnt_q >= H_ACT) : 1'b1;
        vblnk_d    = lock_nxt ? (v_cur >= V_ACT) : 1'b1;
        hsync_d    = hs_q;
        vsync_d    = vs_q;
        locked_d   = lock_nxt;
        sync_err_d = err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q       <= 1'b0;
            hs_dly_q   <= 1'b0;
            vs_q       <= 1'b0;
            vs_dly_q   <= 1'b0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            state_q    <= ST_SEARCH;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            good_q     <= '0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            hblnk_q    <= 1'b1;
            vblnk_q    <= 1'b1;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            hs_q       <= hs_d;
            hs_dly_q   <= hs_dly_d;
            vs_q       <= vs_d;
            vs_dly_q   <= vs_dly_d;
            vld1_q     <= vld1_d;
            vld2_q     <= vld2_d;
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            good_q     <= good_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            hblnk_q    <= hblnk_d;
            vblnk_q    <= vblnk_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hblnk_out  = hblnk_q;
    assign vblnk_out  = vblnk_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of sync_err pulses, cleared only by reset.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed bench for vga_sync_recover using a scaled-down timing (24x10 frame) reference generator.
module tb_vga_sync_recover;

    localparam int HT = 24, HA = 16, HSS = 18, HSW = 3;
    localparam int VT = 10, VA = 6, VSS = 7, VSW = 2, LL = 4;
    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst, hsync_in, vsync_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hblnk_out, vblnk_out, hsync_out, vsync_out, locked, sync_err;
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0, errors = 0;
    int gh = 0, gv = 0, gf = 0;
    int a_h = 0, a_v = 0, a_f = 0, p_h = 0, p_v = 0, p_f = 0;
    logic a_hs = 1'b0, a_vs = 1'b0, p_hs = 1'b0, p_vs = 1'b0;
    int hs_off = 0, hs_w = HSW, vs_off = 0;
    logic hs_kill = 1'b0, chk_en = 1'b0;
    int pulses = 0;

    vga_sync_recover #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .LOCK_LINES(LL)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .locked(locked), .sync_err(sync_err)
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (frame %0d line %0d pix %0d)",
                   tag, obs, exp, p_f, p_v, p_h);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_hcount"}, int'(hcount_out), 0);
        chk({tag, "_vcount"}, int'(vcount_out), 0);
        chk({tag, "_hblnk"}, int'(hblnk_out), 1);
        chk({tag, "_vblnk"}, int'(vblnk_out), 1);
        chk({tag, "_locked"}, int'(locked), 0);
    endtask

    // One pixel clock: drive generator pixel, then observe the pixel applied one step earlier.
    task automatic step();
        logic hs, vs;
        hs = !hs_kill && (gh >= HSS + hs_off) && (gh < HSS + hs_off + hs_w);
        vs = (gv >= VSS + vs_off) && (gv < VSS + VSW + vs_off);
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        #1;
        p_h = a_h; p_v = a_v; p_f = a_f; p_hs = a_hs; p_vs = a_vs;
        a_h = gh;  a_v = gv;  a_f = gf;  a_hs = hs;   a_vs = vs;
        if (sync_err === 1'b1) pulses++;
        if (chk_en) begin
            chk("trk_hcount", int'(hcount_out), p_h);
            chk("trk_vcount", int'(vcount_out), p_v);
            chk("trk_hblnk", int'(hblnk_out), (p_h >= HA) ? 1 : 0);
            chk("trk_vblnk", int'(vblnk_out), (p_v >= VA) ? 1 : 0);
            chk("trk_hsync", int'(hsync_out), int'(p_hs));
            chk("trk_vsync", int'(vsync_out), int'(p_vs));
            chk("trk_locked", int'(locked), 1);
            chk("trk_sync_err", int'(sync_err), 0);
        end
        gh++;
        if (gh == HT) begin
            gh = 0;
            gv++;
            if (gv == VT) begin
                gv = 0;
                gf++;
            end
        end
    endtask

    task automatic run_to(input int f, input int v, input int h);
        int n = 0;
        while (!(p_f == f && p_v == v && p_h == h) && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        assert (n < BUDGET) else begin
            errors++;
            $error("FAIL run_to_timeout: observed %0d cycles expected below %0d", n, BUDGET);
        end
    endtask

    task automatic run_gen_to(input int f, input int v, input int h);
        int n = 0;
        while (!(gf == f && gv == v && gh == h) && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        assert (n < BUDGET) else begin
            errors++;
            $error("FAIL gen_timeout: observed %0d cycles expected below %0d", n, BUDGET);
        end
    endtask

    initial begin
        rst = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("rst");
        chk("rst_hsync", int'(hsync_out), 0);
        chk("rst_vsync", int'(vsync_out), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        rst = 1'b0;

        // First lock at frame 0 vsync rise, after lines 0..3 were good.
        run_to(0, 6, 23);
        chk_idle("prelock");
        run_to(0, 7, 0);
        chk("lock_locked", int'(locked), 1);
        chk("lock_vcount", int'(vcount_out), VSS);
        chk("lock_hcount", int'(hcount_out), 0);
        chk("lock_vsync", int'(vsync_out), 1);
        chk("lock_hblnk", int'(hblnk_out), 0);
        chk("lock_vblnk", int'(vblnk_out), 1);

        // Clean tracking through the end of frame 1.
        pulses = 0;
        chk_en = 1'b1;
        run_to(1, 9, 23);
        chk_en = 1'b0;
        chk("clean_pulses", pulses, 0);

        // hsync shifted by +3 on line 2 of frame 2.
        run_gen_to(2, 2, 0);
        hs_off = 3;
        pulses = 0;
        run_to(2, 2, 17);
        chk("shift_pre_locked", int'(locked), 1);
        run_to(2, 2, 18);
        chk("shift_err", int'(sync_err), 1);
        chk("shift_locked", int'(locked), 0);
        chk("shift_hcount", int'(hcount_out), 0);
        run_to(2, 2, 19);
        chk("shift_err_1cyc", int'(sync_err), 0);
        run_gen_to(2, 3, 0);
        hs_off = 0;
        run_to(2, 6, 23);
        chk("shift_relock_pre", int'(locked), 0);
        run_to(2, 7, 0);
        chk("shift_relock", int'(locked), 1);
        chk("shift_pulses", pulses, 1);

        // Missing hsync on line 2 of frame 3.
        run_gen_to(3, 2, 0);
        hs_kill = 1'b1;
        pulses = 0;
        run_to(3, 2, 18);
        chk("miss_err", int'(sync_err), 1);
        chk("miss_locked", int'(locked), 0);
        run_gen_to(3, 3, 0);
        hs_kill = 1'b0;
        run_to(3, 5, 5);
        chk_idle("miss_idle");
        run_to(3, 7, 0);
        chk("miss_relock", int'(locked), 1);
        chk("miss_pulses", pulses, 1);

        // Short hsync (width-1) on line 2 of frame 4.
        run_gen_to(4, 2, 0);
        hs_w = HSW - 1;
        pulses = 0;
        run_to(4, 2, 19);
        chk("width_pre_err", int'(sync_err), 0);
        run_to(4, 2, 20);
        chk("width_err", int'(sync_err), 1);
        chk("width_locked", int'(locked), 0);
        run_gen_to(4, 3, 0);
        hs_w = HSW;
        run_to(4, 7, 0);
        chk("width_relock", int'(locked), 1);
        chk("width_pulses", pulses, 1);

        // vsync one line late in frame 5.
        run_gen_to(5, 0, 0);
        vs_off = 1;
        pulses = 0;
        run_to(5, 7, 0);
        chk("vlate_pre_locked", int'(locked), 1);
        chk("vlate_pre_err", int'(sync_err), 0);
        run_to(5, 8, 0);
        chk("vlate_err", int'(sync_err), 1);
        chk("vlate_locked", int'(locked), 0);
        run_gen_to(6, 0, 0);
        vs_off = 0;
        run_to(6, 7, 0);
        chk("vlate_relock", int'(locked), 1);
        chk("vlate_pulses", pulses, 1);

        // One-cycle reset mid-frame (frame 7, line 5, pixel 12).
        run_gen_to(7, 5, 12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("mrst");
        chk("mrst_hsync", int'(hsync_out), 0);
        chk("mrst_vsync", int'(vsync_out), 0);
        chk("mrst_sync_err", int'(sync_err), 0);
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
        chk("mrst_err_cnt", int'(err_cnt), 0);
`endif
        pulses = 0;
        run_to(7, 7, 0);
        chk("mrst_no_lock_same_frame", int'(locked), 0);
        run_to(8, 7, 0);
        chk("mrst_relock", int'(locked), 1);
        chk("mrst_vcount", int'(vcount_out), VSS);
        chk("mrst_pulses", pulses, 0);

`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
        // 300 injected errors, one per frame, relocking each time.
        for (int i = 0; i < 300; i++) begin
            run_gen_to(9 + i, 2, 0);
            hs_kill = 1'b1;
            run_gen_to(9 + i, 3, 0);
            hs_kill = 1'b0;
            run_to(9 + i, 7, 0);
        end
        chk("errcnt_sat", int'(err_cnt), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
